// File: rtl/rf_writeback_buffer_pkg.sv
// Register-file constants shared by the writeback buffer, the register file and decode.
package rf_writeback_buffer_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  // Register 0 is hard-wired to zero: never stored, never forwarded.
  localparam logic [RF_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_writeback_buffer_fwd_match.sv
// Youngest-first priority search of the buffered entries for one decode read address.
module rf_writeback_buffer_fwd_match
  import rf_writeback_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
  input  logic [DEPTH-1:0]                 ent_valid,
  input  logic [PTR_W-1:0]                 tail,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // Walk tail-1 down to the oldest slot; valid bits bound the search to occupied
    // entries, and k == DEPTH wraps to tail itself, which is the head when full.
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!hit && ent_valid[idx] && ent_addr[idx] == raddr &&
          raddr != ADDR_WIDTH'(REG_ZERO)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_buffer.sv
// In-order writeback FIFO feeding the register-file write port, with forwarding to decode.
module rf_writeback_buffer
  import rf_writeback_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  drain_en,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic [CNT_W-1:0]      count
);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
  logic [DEPTH-1:0]                 ent_valid;
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic                             push;
  logic                             pop;
  logic                             not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count != CNT_W'(DEPTH));
  // A write to r0 completes the handshake but is dropped.
  assign push      = in_valid && in_ready && (in_waddr != ADDR_WIDTH'(REG_ZERO));
  assign pop       = drain_en && not_empty;

  assign rf_wen    = pop;
  assign rf_waddr  = not_empty ? ent_addr[head] : '0;
  assign rf_wdata  = not_empty ? ent_data[head] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload arrays are not reset; the valid bits and count alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= in_waddr;
      ent_data[tail] <= in_wdata;
    end
  end

  rf_writeback_buffer_fwd_match #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
  ) u_fwd1 (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_valid(ent_valid),
    .tail     (tail),
    .raddr    (fwd_raddr1),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  rf_writeback_buffer_fwd_match #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
  ) u_fwd2 (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_valid(ent_valid),
    .tail     (tail),
    .raddr    (fwd_raddr2),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );

endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Scoreboard bench: accepted pushes queue expected writes, a negedge monitor checks the write port.
module tb_rf_writeback_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        drain_en;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  rf_writeback_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
    .drain_en  (drain_en),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_raddr1(fwd_raddr1),
    .fwd_raddr2(fwd_raddr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_waddr = a;
    in_wdata = d;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("push_ready_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      @(posedge clk);
      if (a != 5'd0) sb.push_back('{a: a, d: d});
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (count != 3'd0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_to_empty", {29'b0, count}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_wen === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_wen", {31'b0, rf_wen}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", {27'b0, rf_waddr}, {27'b0, e.a});
          check("wr_data", rf_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_waddr   = '0;
    in_wdata   = '0;
    drain_en   = 1'b0;
    fwd_raddr1 = '0;
    fwd_raddr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    check("rst_hit1", {31'b0, fwd_hit1}, 32'd0);
    check("rst_data2", fwd_data2, 32'd0);
    @(posedge clk);
    #1;

    // 1: single write, one-cycle latency, then empty
    drain_en = 1'b1;
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_rf_wen", {31'b0, rf_wen}, 32'd1);
    check("t1_count", {29'b0, count}, 32'd1);
    @(negedge clk);
    check("t1_rf_wen_after", {31'b0, rf_wen}, 32'd0);
    check("t1_count_after", {29'b0, count}, 32'd0);
    @(posedge clk);
    #1;

    // 2: fill to full, fifth held until drain enabled, in-order drain
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    fork
      push(5'd5, 32'h55);
      begin
        repeat (2) @(negedge clk);
        check("t2_count_full", {29'b0, count}, 32'd4);
        check("t2_in_ready_full", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        drain_en = 1'b1;
      end
    join
    wait_empty();

    // 3: youngest-match forwarding
    drain_en = 1'b0;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    fwd_raddr1 = 5'd7;
    fwd_raddr2 = 5'd8;
    @(negedge clk);
    check("t3_hit1", {31'b0, fwd_hit1}, 32'd1);
    check("t3_data1", fwd_data1, 32'hB);
    check("t3_hit2", {31'b0, fwd_hit2}, 32'd0);
    check("t3_data2", fwd_data2, 32'd0);
    @(posedge clk);
    #1;
    drain_en = 1'b1;
    @(posedge clk);
    #1;
    drain_en = 1'b0;
    @(negedge clk);
    check("t3_hit1_after_pop", {31'b0, fwd_hit1}, 32'd1);
    check("t3_data1_after_pop", fwd_data1, 32'hB);
    @(posedge clk);
    #1;
    drain_en = 1'b1;
    wait_empty();

    // 4: write to r0 is accepted but dropped
    push(5'd0, 32'h1234);
    fwd_raddr1 = 5'd0;
    @(negedge clk);
    check("t4_count", {29'b0, count}, 32'd0);
    check("t4_rf_wen", {31'b0, rf_wen}, 32'd0);
    check("t4_hit1", {31'b0, fwd_hit1}, 32'd0);
    @(posedge clk);
    #1;

    // 5: full buffer, push and drain together, tail wraps to slot 0
    do_reset();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i + 10), 32'(32'hC0 + i));
    drain_en = 1'b1;
    @(negedge clk);
    check("t5_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("t5_count_full", {29'b0, count}, 32'd4);
    #5;
    #1;
    push(5'd9, 32'h99);
    drain_en = 1'b0;
    fwd_raddr1 = 5'd9;
    fwd_raddr2 = 5'd14;
    @(negedge clk);
    check("t5_count_after", {29'b0, count}, 32'd3);
    check("t5_wrap_hit1", {31'b0, fwd_hit1}, 32'd1);
    check("t5_wrap_data1", fwd_data1, 32'h99);
    check("t5_data2", fwd_data2, 32'hC4);
    @(posedge clk);
    #1;
    drain_en = 1'b1;
    wait_empty();

    // 6: reset discards queued entries
    drain_en = 1'b0;
    push(5'd3, 32'h333);
    push(5'd4, 32'h444);
    push(5'd5, 32'h555);
    fwd_raddr1 = 5'd3;
    fwd_raddr2 = 5'd5;
    do_reset();
    @(negedge clk);
    check("t6_rf_wen", {31'b0, rf_wen}, 32'd0);
    check("t6_count", {29'b0, count}, 32'd0);
    check("t6_hit1", {31'b0, fwd_hit1}, 32'd0);
    check("t6_hit2", {31'b0, fwd_hit2}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    drain_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_writeback_buffer.md
Name: rf_writeback_buffer

Overview:
- Write-side initiator for the 32x32 register file, with one write port (wen/waddr/wdata) and reads of address 0 returning zero.
- Accepts writeback results from execute/memory stages through a valid/ready handshake.
- Buffers results in a small in-order FIFO and drains one entry per cycle onto the register-file write port.
- Offers youngest-match forwarding of buffered-but-unwritten data to both register read addresses, so decode sees the correct values before the write lands.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer offers a result
in_ready  output  1  buffer can accept a result this cycle
in_waddr  input  ADDR_WIDTH  destination register
in_wdata  input  DATA_WIDTH  result data
drain_en  input  1  permits a register-file write this cycle
rf_wen  output  1  register-file write enable
rf_waddr  output  ADDR_WIDTH  register-file write address
rf_wdata  output  DATA_WIDTH  register-file write data
fwd_raddr1  input  ADDR_WIDTH  decode read address 1
fwd_raddr2  input  ADDR_WIDTH  decode read address 2
fwd_hit1  output  1  buffered entry matches fwd_raddr1
fwd_hit2  output  1  buffered entry matches fwd_raddr2
fwd_data1  output  DATA_WIDTH  forwarded data for raddr1 (0 when no hit)
fwd_data2  output  DATA_WIDTH  forwarded data for raddr2 (0 when no hit)
count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- State: entry arrays (addr, data, valid), head pointer, tail pointer, count.
- Pointers wrap modulo DEPTH.
- Reset (rst high at a clk edge): head=tail=0, count=0, all entry valid bits cleared.
- Reset values and behaviour during reset:
  - rf_wen=0, fwd_hit1/2=0, fwd_data1/2=0, count=0, in_ready=1 during the cycle after reset.
  - rst has priority over push and pop in the same cycle.
  - Entries in flight when reset arrives are discarded and not written.
- Push: on the edge where in_valid && in_ready.
  - If in_waddr!=0: the entry is stored at tail, tail++ and count++.
  - If in_waddr==0: the handshake completes but nothing is stored.
- in_ready = (count!=DEPTH). It is combinational from state only and does not depend on the pop in the same cycle.
- Pop:
  - rf_wen = drain_en && (count!=0).
  - rf_waddr/rf_wdata = head entry, held at 0 when empty.
  - On an edge with rf_wen=1 the register file captures the write; head++ and count-- on the same edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Latency:
  - An entry pushed at edge N into an empty buffer drives rf_wen in cycle N+1.
  - The register file is written at edge N+1 if drain_en is high.
  - Without forwarding, the value is readable from the register file in cycle N+2.
- Ordering: strictly in order, so repeated writes to one register reach the register file oldest first.
- Forwarding (combinational):
  - For each read port, search all valid entries, including the head being popped this cycle.
  - The youngest matching entry (closest to tail) wins.
  - raddr==0 never hits.
  - The input port (not yet accepted) is not searched.
  - A hit sets fwd_hitX=1 and fwd_dataX=entry data; otherwise 0/0.
- Full with drain_en=0: in_ready=0, and the producer holds in_valid/in_waddr/in_wdata stable.
- Empty with drain_en=1: rf_wen=0; no underflow.
- Guarantees: count never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH constants and a reg-zero address constant, shared with the register file and decode.
- Sub-module fwd_match: a priority search, youngest-first from tail-1 down to head, over the entry arrays. It returns hit and data for one read address and is instantiated twice.

Test Plan:
1. Reset then push (r5, 0xDEADBEEF) with drain_en=1 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, count=0 and rf_wen=0.
2. drain_en=0, push r1..r4 with data 0x11..0x44 -> count=4, in_ready=0. A fifth in_valid is held until drain_en=1; drains then appear in order 0x11,0x22,0x33,0x44, then the fifth entry.
3. drain_en=0, push (r7,0xA), (r7,0xB) -> fwd_raddr1=7 gives hit1=1, data1=0xB; fwd_raddr2=8 gives hit2=0, data2=0.
4. Push (r0, 0x1234) -> handshake accepted, count stays 0, no rf_wen, fwd_raddr1=0 gives hit1=0.
5. Full buffer, push and drain in the same cycle -> in_ready=0 so no push; count goes 4->3. The next cycle's push and pop leave count at 3, and the tail wraps to index 0 correctly.
6. Three entries queued, rst=1 for one cycle -> rf_wen=0, count=0, hit1/2=0; queued entries are never written.
